// File: rtl/clock_monitor.sv
// Lock/loss monitor for a slow clock (e.g. phi0) measured against clkin: counts
// synchronized rising edges of clk_mon per gate window and tracks lock and clock loss.
module clock_monitor #(
  parameter int WINDOW  = 1024,
  parameter int CNT_W   = 12,
  parameter int EXP_MIN = 120,
  parameter int EXP_MAX = 136,
  parameter int GOOD_N  = 4,
  parameter int STALL   = 256
) (
  input  logic             clkin,
  input  logic             RST,
  input  logic             clk_mon,
  input  logic             enable,
  output logic [CNT_W-1:0] meas_count,
  output logic             meas_valid,
  output logic             in_range,
  output logic             locked,
  output logic             clk_lost,
  output logic [1:0]       state
);
  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int STL_W = (STALL > 1) ? $clog2(STALL) : 1;
  localparam int GD_W  = $clog2(GOOD_N + 1);
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WINDOW - 1);
  localparam logic [STL_W-1:0] STL_LAST  = STL_W'(STALL - 1);
  localparam logic [GD_W-1:0]  GOOD_LAST = GD_W'(GOOD_N - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_t;

  state_t           cur;
  state_t           nxt;
  logic             sync_p0, sync_p1, dly_p2;
  logic             mon_edge;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] total;
  logic [STL_W-1:0] stall_cnt;
  logic [GD_W-1:0]  good_cnt;
  logic             active, close, stalled, good_win;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    if (inc && (c != {CNT_W{1'b1}})) return c + CNT_W'(1);
    return c;
  endfunction

  function automatic logic in_window(input logic [CNT_W-1:0] c);
    logic [31:0] cx;
    cx = 32'(c);
    return (cx >= 32'(EXP_MIN)) && (cx <= 32'(EXP_MAX));
  endfunction

  // Stage boundary: synchronizer output p1 against delay flop p2 gives one-cycle edge
  assign mon_edge = sync_p1 & ~dly_p2;
  assign state    = cur;

  always_comb begin
    active   = (cur == ACQUIRE) || (cur == LOCKED);
    close    = active && (win_cnt == WIN_LAST);
    total    = sat_inc(edge_cnt, mon_edge);
    good_win = in_window(total);
    stalled  = active && !mon_edge && (stall_cnt == STL_LAST);
    nxt      = cur;
    case (cur)
      IDLE:    nxt = ACQUIRE;
      ACQUIRE: begin
        if (stalled) nxt = LOST;
        else if (close && good_win && (good_cnt == GOOD_LAST)) nxt = LOCKED;
      end
      LOCKED: begin
        if (stalled) nxt = LOST;
        else if (close && !good_win) nxt = ACQUIRE;
      end
      LOST:    if (mon_edge) nxt = ACQUIRE;
      default: nxt = IDLE;
    endcase
    if (!enable) nxt = IDLE;
  end

  always_ff @(posedge clkin) begin
    if (RST) begin
      cur        <= IDLE;
      sync_p0    <= 1'b0;
      sync_p1    <= 1'b0;
      dly_p2     <= 1'b0;
      win_cnt    <= '0;
      edge_cnt   <= '0;
      stall_cnt  <= '0;
      good_cnt   <= '0;
      meas_count <= '0;
      meas_valid <= 1'b0;
      in_range   <= 1'b0;
      locked     <= 1'b0;
      clk_lost   <= 1'b0;
    end else begin
      sync_p0    <= clk_mon;
      sync_p1    <= sync_p0;
      dly_p2     <= sync_p1;
      meas_valid <= 1'b0;
      cur        <= nxt;
      locked     <= (nxt == LOCKED);
      clk_lost   <= (nxt == LOST);
      if (!enable || (cur == IDLE)) begin
        win_cnt   <= '0;
        edge_cnt  <= '0;
        stall_cnt <= '0;
        good_cnt  <= '0;
      end else if (cur == LOST) begin
        // The edge that ends a loss is the first edge of the new window
        win_cnt   <= '0;
        edge_cnt  <= CNT_W'(mon_edge);
        stall_cnt <= '0;
        good_cnt  <= '0;
      end else begin
        if (close) begin
          meas_count <= total;
          in_range   <= good_win;
          meas_valid <= 1'b1;
          win_cnt    <= '0;
          edge_cnt   <= '0;
        end else begin
          win_cnt  <= win_cnt + WIN_W'(1);
          edge_cnt <= total;
        end
        stall_cnt <= mon_edge ? '0 : stall_cnt + STL_W'(1);
        if (stalled) begin
          win_cnt   <= '0;
          edge_cnt  <= '0;
          stall_cnt <= '0;
          good_cnt  <= '0;
        end else if (close) begin
          if (!good_win) good_cnt <= '0;
          else if (cur == ACQUIRE) good_cnt <= good_cnt + GD_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_clock_monitor.sv
// Bench for clock_monitor: window-level behavioural model checked every cycle,
// plus directed lock / unlock / loss / reset / saturation scenarios.
module tb_clock_monitor;
  localparam int WINDOW  = 1024;
  localparam int EXP_MIN = 120;
  localparam int EXP_MAX = 136;
  localparam int GOOD_N  = 4;
  localparam int STALL   = 256;
  localparam int MAXC    = 4095;
  localparam int S_IDLE = 0, S_ACQ = 1, S_LOCK = 2, S_LOST = 3;

  logic        clkin, RST, clk_mon, enable;
  logic [11:0] meas_count;
  logic        meas_valid, in_range, locked, clk_lost;
  logic [1:0]  state;
  logic        clk_mon2, enable2;
  logic [5:0]  mc2;
  logic        mv2, ir2, lk2, cl2;
  logic [1:0]  st2;

  int tests = 0, fails = 0;
  int div = 0, div2 = 0;
  bit chk_on = 0;

  clock_monitor dut (
    .clkin(clkin), .RST(RST), .clk_mon(clk_mon), .enable(enable),
    .meas_count(meas_count), .meas_valid(meas_valid), .in_range(in_range),
    .locked(locked), .clk_lost(clk_lost), .state(state)
  );

  clock_monitor #(.CNT_W(6)) dut6 (
    .clkin(clkin), .RST(RST), .clk_mon(clk_mon2), .enable(enable2),
    .meas_count(mc2), .meas_valid(mv2), .in_range(ir2),
    .locked(lk2), .clk_lost(cl2), .state(st2)
  );

  task automatic check(input string name, input logic [31:0] act, input int exp);
    tests++;
    if (act !== 32'(exp)) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    clkin = 1'b0;
    forever #5 clkin = ~clkin;
  end

  // Monitored clocks: square waves at clkin/div, changed on the falling edge
  initial begin
    int ph = 0;
    int ph2 = 0;
    clk_mon = 1'b0;
    clk_mon2 = 1'b0;
    forever begin
      @(negedge clkin);
      if (div == 0) begin ph = 0; clk_mon = 1'b0; end
      else begin ph = (ph + 1) % div; clk_mon = (ph < div / 2); end
      if (div2 == 0) begin ph2 = 0; clk_mon2 = 1'b0; end
      else begin ph2 = (ph2 + 1) % div2; clk_mon2 = (ph2 < div2 / 2); end
    end
  end

  // Behavioural model: window position, unbounded edge tally, cycles since last edge
  int m_st = S_IDLE, m_win = 0, m_edges = 0, m_since = 0, m_good = 0, m_count = 0;
  bit m_valid = 0, m_inr = 0;
  bit h0 = 0, h1 = 0, h2 = 0;
  int cyc = 0, last_edge_cyc = 0;

  task automatic model_step();
    bit e, close, stalled, good_w;
    int total;
    cyc++;
    if (RST) begin
      m_st = S_IDLE; m_win = 0; m_edges = 0; m_since = 0; m_good = 0;
      m_count = 0; m_valid = 0; m_inr = 0; h0 = 0; h1 = 0; h2 = 0;
      return;
    end
    // clk_mon takes two sync stages; a rise is seen when the newer of the pair is 1
    e = h1 && !h2;
    h2 = h1; h1 = h0; h0 = clk_mon;
    if (e) last_edge_cyc = cyc;
    m_valid = 0;
    if (!enable) begin
      m_st = S_IDLE; m_win = 0; m_edges = 0; m_since = 0; m_good = 0;
      return;
    end
    case (m_st)
      S_IDLE: begin
        m_st = S_ACQ; m_win = 0; m_edges = 0; m_since = 0; m_good = 0;
      end
      S_LOST: begin
        if (e) begin m_st = S_ACQ; m_win = 0; m_edges = 1; m_since = 0; end
      end
      default: begin
        total   = m_edges + int'(e);
        close   = (m_win == WINDOW - 1);
        stalled = !e && (m_since == STALL - 1);
        good_w  = 0;
        if (close) begin
          m_count = (total > MAXC) ? MAXC : total;
          m_inr   = (m_count >= EXP_MIN) && (m_count <= EXP_MAX);
          m_valid = 1;
          good_w  = m_inr;
        end
        m_win   = close ? 0 : m_win + 1;
        m_edges = close ? 0 : total;
        m_since = e ? 0 : m_since + 1;
        if (stalled) begin
          m_st = S_LOST; m_win = 0; m_edges = 0; m_since = 0; m_good = 0;
        end else if (close) begin
          if (!good_w) begin m_good = 0; m_st = S_ACQ; end
          else if (m_st == S_ACQ) begin
            m_good++;
            if (m_good == GOOD_N) m_st = S_LOCK;
          end
        end
      end
    endcase
  endtask

  initial forever begin
    @(posedge clkin);
    model_step();
  end

  initial forever begin
    @(negedge clkin);
    if (chk_on) begin
      check("state", 32'(state), m_st);
      check("locked", 32'(locked), int'(m_st == S_LOCK));
      check("clk_lost", 32'(clk_lost), int'(m_st == S_LOST));
      check("meas_valid", 32'(meas_valid), int'(m_valid));
      check("meas_count", 32'(meas_count), m_count);
      check("in_range", 32'(in_range), int'(m_inr));
    end
  end

  int n2 = 0;
  initial forever begin
    @(negedge clkin);
    if (chk_on && mv2 === 1'b1) begin
      check("sat_count", 32'(mc2), 63);
      check("sat_in_range", 32'(ir2), 0);
      n2++;
    end
  end

  task automatic wait_valid(input string name, output bit ok);
    ok = 0;
    for (int i = 0; i < 3 * WINDOW; i++) begin
      @(negedge clkin);
      if (meas_valid) begin ok = 1; return; end
    end
    check({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_locked(input string name);
    for (int i = 0; i < 7 * WINDOW; i++) begin
      @(negedge clkin);
      if (locked) return;
    end
    check({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    bit ok;
    int saved;
    RST = 1'b1; enable = 1'b0; enable2 = 1'b0;
    @(negedge clkin);
    chk_on = 1;
    @(negedge clkin);
    check("rst_state", 32'(state), 0);
    check("rst_count", 32'(meas_count), 0);
    check("rst_valid", 32'(meas_valid), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_lost", 32'(clk_lost), 0);
    RST = 1'b0;

    // Nominal clkin/8: 127 or 128 edges per window, lock on the 4th report
    enable = 1'b1; enable2 = 1'b1; div = 8; div2 = 4;
    for (int k = 1; k <= 4; k++) begin
      wait_valid("nominal", ok);
      check("nominal_count_127_128", 32'((meas_count == 127) || (meas_count == 128)), 1);
      check("nominal_in_range", 32'(in_range), 1);
      check("lock_only_at_4th", 32'(locked), int'(k == 4));
    end

    // Fast clock clkin/6 (~170 edges) drops lock at the very next report
    div = 6;
    wait_valid("fast", ok);
    check("fast_in_range", 32'(in_range), 0);
    check("fast_count_high", 32'(meas_count > 160), 1);
    check("fast_state_acq", 32'(state), 1);
    check("fast_locked", 32'(locked), 0);

    // Regain lock, then stop clk_mon: loss exactly STALL cycles after the last edge
    div = 8;
    wait_locked("relock");
    div = 0;
    for (int i = 0; i < 2 * STALL + 20; i++) begin
      @(negedge clkin);
      if (clk_lost) break;
    end
    check("lost_flag", 32'(clk_lost), 1);
    check("lost_state", 32'(state), 3);
    check("lost_delay", 32'(cyc - last_edge_cyc), STALL);
    div = 8;
    for (int i = 0; i < 50; i++) begin
      @(negedge clkin);
      if (state != 2'd3) break;
    end
    check("restart_state", 32'(state), 1);
    check("restart_on_first_edge", 32'(cyc - last_edge_cyc), 0);

    // Three good windows, one slow (clkin/10, ~102 edges) window, then four more to lock
    for (int k = 1; k <= 3; k++) begin
      wait_valid("acq_good", ok);
      check("acq_good_in_range", 32'(in_range), 1);
      check("acq_not_locked", 32'(locked), 0);
    end
    div = 10;
    wait_valid("slow", ok);
    check("slow_in_range", 32'(in_range), 0);
    check("slow_count_low", 32'(meas_count < 110), 1);
    check("slow_state_acq", 32'(state), 1);
    div = 8;
    for (int k = 1; k <= 4; k++) begin
      wait_valid("reacq", ok);
      check("reacq_lock_only_at_4th", 32'(locked), int'(k == 4));
    end

    // Reset mid-window while locked, enable held
    repeat (300) @(negedge clkin);
    RST = 1'b1;
    @(negedge clkin);
    check("midrst_state", 32'(state), 0);
    check("midrst_count", 32'(meas_count), 0);
    check("midrst_in_range", 32'(in_range), 0);
    check("midrst_locked", 32'(locked), 0);
    RST = 1'b0;
    @(negedge clkin);
    check("postrst_acq", 32'(state), 1);

    // Drop enable in the window-closing cycle: no report, last result held
    for (int i = 0; i < 2 * WINDOW; i++) begin
      @(negedge clkin);
      if (meas_valid) break;
    end
    saved = int'(meas_count);
    for (int i = 0; i < 2 * WINDOW; i++) begin
      if (m_win == WINDOW - 1 && m_st == S_ACQ) break;
      @(negedge clkin);
    end
    check("close_cycle_reached", 32'(m_win), WINDOW - 1);
    enable = 1'b0;
    @(negedge clkin);
    check("disable_no_valid", 32'(meas_valid), 0);
    check("disable_idle", 32'(state), 0);
    check("disable_count_held", 32'(meas_count), saved);
    repeat (5) @(negedge clkin);
    check("sat_windows_seen", 32'(n2 >= 2), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/clock_monitor.md
CLOCK_MONITOR -- requirements
Module: clock_monitor

Interface
REQ-001 SHALL have parameter WINDOW, default 1024, meaning the measurement gate length in clkin cycles (at least 4).
REQ-002 SHALL have parameter CNT_W, default 12, meaning the width of the edge counter and of meas_count.
REQ-003 SHALL have parameter EXP_MIN, default 120, meaning the minimum number of edges per window that counts as good.
REQ-004 SHALL have parameter EXP_MAX, default 136, meaning the maximum number of edges per window that counts as good.
REQ-005 SHALL have parameter GOOD_N, default 4, meaning the number of consecutive good windows required to declare lock.
REQ-006 SHALL have parameter STALL, default 256, meaning the number of clkin cycles without a monitored edge that declares clock loss.
REQ-007 SHALL have port clkin, input, 1 bit: reference clock; all logic is clocked on its rising edge.
REQ-008 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port clk_mon, input, 1 bit: monitored divided clock (for example phi0), asynchronous to clkin and slower than clkin/2.
REQ-010 SHALL have port enable, input, 1 bit: monitoring enable.
REQ-011 SHALL have port meas_count, output, CNT_W bits: edge count of the last completed window.
REQ-012 SHALL have port meas_valid, output, 1 bit: one-cycle pulse when meas_count and in_range update.
REQ-013 SHALL have port in_range, output, 1 bit: high when EXP_MIN <= meas_count <= EXP_MAX.
REQ-014 SHALL have port locked, output, 1 bit: high while in state LOCKED.
REQ-015 SHALL have port clk_lost, output, 1 bit: high while in state LOST.
REQ-016 SHALL have port state, output, 2 bits: IDLE=0, ACQUIRE=1, LOCKED=2, LOST=3.

Function
REQ-017 SHALL pass clk_mon through a two-flop synchronizer followed by a delay flop; edge is high for one cycle when sync2=1 and the delay flop=0.
REQ-018 SHALL run the window counter 0..WINDOW-1, wrapping to 0, only in ACQUIRE and LOCKED; it is held at 0 otherwise.
REQ-019 SHALL increment the edge counter on each edge, saturating at 2^CNT_W-1.
REQ-020 SHALL include an edge that arrives in the window-closing cycle (window counter = WINDOW-1) in the closing window's total.
REQ-021 SHALL, in the cycle after window close, load meas_count with the saturated total, register in_range, pulse meas_valid, and clear the edge counter for the next window with no dead cycle.
REQ-022 SHALL evaluate the good/bad window decision with the same comparison as in_range.
REQ-023 SHALL clear the stall counter on every edge, increment it otherwise in ACQUIRE and LOCKED, and hold it at 0 in IDLE and LOST.
REQ-024 SHALL implement the IDLE->ACQUIRE transition when enable=1, clearing the window counter, edge counter and good-window counter.
REQ-025 SHALL, in ACQUIRE, increment the good-window counter on a good window, zero it on a bad window, and go to LOCKED when it reaches GOOD_N.
REQ-026 SHALL, in LOCKED, go to ACQUIRE on a bad window with the good-window counter zeroed; good windows keep the state.
REQ-027 SHALL go from ACQUIRE or LOCKED to LOST when the stall counter reaches STALL-1 with no edge in that cycle.
REQ-028 SHALL, in LOST, go to ACQUIRE on the first edge, restarting the window counter and edge counter from 0; that edge counts as 1.
REQ-029 SHALL return any state to IDLE the cycle after enable=0; meas_count and in_range hold their last values.
REQ-030 SHALL give stall priority over a simultaneous window close: the state goes to LOST, meas_valid still pulses, and the lock decision is discarded.
REQ-031 SHALL let a window that closes in the same cycle enable falls go unreported: no meas_valid.
REQ-032 SHALL produce locked, clk_lost and state as registered decodes of the state register, with no combinational path from clk_mon.

Reset
REQ-033 SHALL, while RST=1 at a clkin edge, set state=IDLE and clear all counters, synchronizer flops, meas_count, meas_valid, in_range, locked and clk_lost to 0.
REQ-034 SHALL give RST priority over enable and all other events, including mid-window; the next enable starts a fresh window.

Verification
REQ-035 SHALL cover: defaults, enable=1, clk_mon=clkin/8 -> meas_count in {127,128}, in_range=1 at every window, locked=1 after the 4th meas_valid.
REQ-036 SHALL cover: locked, then clk_mon=clkin/6 (about 170 edges) -> in_range=0 at the next meas_valid; state=ACQUIRE and locked=0 the same cycle.
REQ-037 SHALL cover: locked, then clk_mon held at 0 -> clk_lost=1 and state=3 exactly STALL cycles after the last edge; restart clk_mon -> ACQUIRE on the first edge.
REQ-038 SHALL cover: ACQUIRE with 3 good windows, then 1 window at clkin/10 (about 102 edges) -> good counter resets; 4 more good windows are needed for lock.
REQ-039 SHALL cover: RST pulsed mid-window while LOCKED -> all outputs 0 and state=IDLE the next cycle; with enable held, ACQUIRE the following cycle.
REQ-040 SHALL cover: CNT_W=6 with clk_mon=clkin/4 -> meas_count saturates at 63.
